// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-like datapath with one shared memory port, non-architectural
// IR/Data/A/B/ALUOut registers and a MemReady stall. Define MC_DATAPATH_MUL_EN for ALU MUL.
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              AdrSrc,
    input  logic              IRWrite,
    input  logic [1:0]        RegSrc,
    input  logic              RegWrite,
    input  logic [1:0]        ImmSrc,
    input  logic              ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic [2:0]        ALUControl,
    input  logic [1:0]        ResultSrc,
    input  logic              MemReady,
    input  logic [31:0]       ReadData,
    output logic [ADDR_W-1:0] Adr,
    output logic [31:0]       WriteData,
    output logic [31:0]       Instr,
    output logic [3:0]        ALUFlags,
    output logic [31:0]       PC
);

    localparam int DATA_W = 32;
    localparam int NREGS  = 15;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_ORR  = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_EOR  = 3'b101,
        ALU_MOV  = 3'b110,
        ALU_ZERO = 3'b111
    } alu_op_t;

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] aluout_q;
    logic [DATA_W-1:0] rf [0:NREGS-1];

    logic [3:0]        ra1;
    logic [3:0]        ra2;
    logic [3:0]        wa;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   dif_w;
    logic [DATA_W-1:0] alu_result;
    logic              flag_c;
    logic              flag_v;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] adr_full;

    // Register-file addressing; R15 is not stored, it reads back as Result.
    assign ra1 = RegSrc[0] ? 4'd15 : ir_q[19:16];
    assign ra2 = RegSrc[1] ? ir_q[15:12] : ir_q[3:0];
    assign wa  = ir_q[15:12];
    assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
    assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];

    always_comb begin
        ext_imm = '0;
        case (ImmSrc)
            2'b00:   ext_imm = {24'd0, ir_q[7:0]};
            2'b01:   ext_imm = {20'd0, ir_q[11:0]};
            2'b10:   ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        src_a = ALUSrcA ? pc_q : a_q;
        src_b = '0;
        case (ALUSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = 32'd4;
            default: src_b = '0;
        endcase
    end

    // Both add and subtract are formed 33 bits wide so the carry/borrow falls out of bit 32.
    assign sum_w = {1'b0, src_a} + {1'b0, src_b};
    assign dif_w = {1'b0, src_a} - {1'b0, src_b};

    always_comb begin
        alu_result = '0;
        flag_c     = 1'b0;
        flag_v     = 1'b0;
        case (alu_op_t'(ALUControl))
            ALU_ADD: begin
                alu_result = sum_w[DATA_W-1:0];
                flag_c     = sum_w[DATA_W];
                flag_v     = (src_a[31] == src_b[31]) && (alu_result[31] != src_a[31]);
            end
            ALU_SUB: begin
                alu_result = dif_w[DATA_W-1:0];
                flag_c     = ~dif_w[DATA_W];
                flag_v     = (src_a[31] != src_b[31]) && (alu_result[31] != src_a[31]);
            end
            ALU_AND: alu_result = src_a & src_b;
            ALU_ORR: alu_result = src_a | src_b;
            ALU_EOR: alu_result = src_a ^ src_b;
            ALU_MOV: alu_result = src_b;
`ifdef MC_DATAPATH_MUL_EN
            ALU_MUL: alu_result = src_a * src_b;
`else
            ALU_MUL: alu_result = '0;
`endif
            default: alu_result = '0;
        endcase
    end

    assign ALUFlags = {alu_result[31], (alu_result == '0), flag_c, flag_v};

    always_comb begin
        result = '0;
        case (ResultSrc)
            2'b00:   result = aluout_q;
            2'b01:   result = data_q;
            2'b10:   result = alu_result;
            default: result = '0;
        endcase
    end

    assign adr_full  = AdrSrc ? result : pc_q;
    assign Adr       = adr_full[ADDR_W-1:0];
    assign WriteData = b_q;
    assign Instr     = ir_q;
    assign PC        = pc_q;

    // State registers: reset wins over a stall; otherwise nothing moves while MemReady is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else if (MemReady) begin
            if (PCWrite) pc_q <= result;
            if (IRWrite) ir_q <= ReadData;
            data_q   <= ReadData;
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (MemReady && RegWrite && (wa != 4'd15)) begin
            rf[wa] <= result;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed scenarios plus randomized cycles
// compared against a behavioural model of the datapath state.
module tb_mc_datapath;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic        AdrSrc;
    logic        IRWrite;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        MemReady;
    logic [31:0] ReadData;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic [31:0] PC;

    logic [31:0] mem [0:255];
    assign ReadData = mem[Adr[9:2]];

    mc_datapath #(.RESET_PC(RPC), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .MemReady(MemReady), .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData),
        .Instr(Instr), .ALUFlags(ALUFlags), .PC(PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_rf [0:14];

    function automatic logic [31:0] ref_imm(input logic [1:0] src, input logic [31:0] ins);
        logic signed [31:0] s;
        s = $signed({{8{ins[23]}}, ins[23:0]});
        case (src)
            2'd0:    return {24'd0, ins[7:0]};
            2'd1:    return {20'd0, ins[11:0]};
            2'd2:    return s * 4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] fl);
        logic [63:0] w;
        longint s;
        logic c, v;
        c = 1'b0; v = 1'b0; r = 32'd0;
        case (op)
            3'd0: begin
                w = {32'd0, a} + {32'd0, b}; r = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b; c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = b;
`ifdef MC_DATAPATH_MUL_EN
            3'd4: begin w = {32'd0, a} * {32'd0, b}; r = w[31:0]; end
`endif
            default: r = 32'd0;
        endcase
        fl = {r[31], (r == 32'd0), c, v};
    endtask

    task automatic mcomb(output logic [31:0] alu_r, output logic [3:0] fl, output logic [31:0] res);
        logic [31:0] sa, sb;
        sa = ALUSrcA ? m_pc : m_a;
        case (ALUSrcB)
            2'd0:    sb = m_b;
            2'd1:    sb = ref_imm(ImmSrc, m_ir);
            2'd2:    sb = 32'd4;
            default: sb = 32'd0;
        endcase
        ref_alu(ALUControl, sa, sb, alu_r, fl);
        case (ResultSrc)
            2'd0:    res = m_aluout;
            2'd1:    res = m_data;
            2'd2:    res = alu_r;
            default: res = 32'd0;
        endcase
    endtask

    task automatic idle();
        reset = 1'b0; PCWrite = 1'b0; AdrSrc = 1'b0; IRWrite = 1'b0; RegSrc = 2'd0;
        RegWrite = 1'b0; ImmSrc = 2'd0; ALUSrcA = 1'b0; ALUSrcB = 2'd0; ALUControl = 3'd0;
        ResultSrc = 2'd0; MemReady = 1'b1;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic [31:0] alu_r, res, adr, rd, rd1, rd2;
        logic [3:0]  fl, ra1, ra2, wa;
        mcomb(alu_r, fl, res);
        adr = AdrSrc ? res : m_pc;
        rd  = mem[adr[9:2]];
        ra1 = RegSrc[0] ? 4'd15 : m_ir[19:16];
        ra2 = RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
        wa  = m_ir[15:12];
        rd1 = (ra1 == 4'd15) ? res : m_rf[ra1];
        rd2 = (ra2 == 4'd15) ? res : m_rf[ra2];
        @(posedge clk);
        #1;
        if (reset) begin
            m_pc = RPC; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
            for (int i = 0; i < 15; i++) m_rf[i] = 0;
        end else if (MemReady) begin
            if (RegWrite && wa != 4'd15) m_rf[wa] = res;
            if (PCWrite) m_pc = res;
            if (IRWrite) m_ir = rd;
            m_data = rd; m_a = rd1; m_b = rd2; m_aluout = alu_r;
        end
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [31:0] val);
        mem[0] = {16'h0000, r, 12'h000};
        idle(); AdrSrc = 1'b1; ResultSrc = 2'd3; IRWrite = 1'b1; tick();
        mem[0] = val;
        idle(); AdrSrc = 1'b1; ResultSrc = 2'd3; tick();
        idle(); ResultSrc = 2'd1; RegWrite = 1'b1; tick();
    endtask

    task automatic load_ab(input logic [31:0] x, input logic [31:0] y);
        write_reg(4'd2, x);
        write_reg(4'd3, y);
        mem[0] = 32'h0002_0003;
        idle(); AdrSrc = 1'b1; ResultSrc = 2'd3; IRWrite = 1'b1; tick();
        idle(); tick();
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; tick(); tick();
        idle(); #1;
        checks++; if (PC !== RPC) begin errors++; $display("FAIL reset_pc got %h want %h", PC, RPC); end
        checks++; if (Instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", Instr); end
        checks++; if (Adr !== RPC) begin errors++; $display("FAIL reset_adr got %h want %h", Adr, RPC); end
        checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_b got %h want 0", WriteData); end
        AdrSrc = 1'b1; ResultSrc = 2'd0; #1;
        checks++; if (Adr !== 32'd0) begin errors++; $display("FAIL reset_aluout got %h want 0", Adr); end
    endtask

    task automatic test_regwrite();
        mem[0] = 32'hE3A0_1007;
        idle(); AdrSrc = 1'b1; ResultSrc = 2'd3; IRWrite = 1'b1; tick();
        checks++; if (PC !== RPC) begin errors++; $display("FAIL irload_pc got %h want %h", PC, RPC); end
        idle(); ALUSrcB = 2'd1; ALUControl = 3'd6; ResultSrc = 2'd2; RegWrite = 1'b1; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'd7) begin errors++; $display("FAIL mov_result got %h want 7", Adr); end
        checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL mov_flags got %b want 0000", ALUFlags); end
        tick();
    endtask

    task automatic test_fetch();
        mem[64] = 32'hE281_0005;
        idle(); IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2; PCWrite = 1'b1; #1;
        checks++; if (Adr !== 32'h100) begin errors++; $display("FAIL fetch_adr got %h want 100", Adr); end
        tick();
        checks++; if (Instr !== 32'hE281_0005) begin errors++; $display("FAIL fetch_instr got %h want e2810005", Instr); end
        checks++; if (PC !== 32'h104) begin errors++; $display("FAIL fetch_pc got %h want 104", PC); end
    endtask

    task automatic test_decode_add();
        idle(); RegSrc = 2'b01; ALUSrcA = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'h108) begin errors++; $display("FAIL r15_result got %h want 108", Adr); end
        tick();
        idle(); ALUSrcB = 2'd3; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'h108) begin errors++; $display("FAIL r15_in_a got %h want 108", Adr); end
        tick();
        idle(); ALUSrcB = 2'd1; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'd12) begin errors++; $display("FAIL add_exec got %h want c", Adr); end
        checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL add_flags got %b want 0000", ALUFlags); end
        tick();
        idle(); ResultSrc = 2'd0; RegWrite = 1'b1; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'd12) begin errors++; $display("FAIL add_aluout got %h want c", Adr); end
        tick();
        idle(); RegSrc = 2'b10; tick();
        checks++; if (WriteData !== 32'd12) begin errors++; $display("FAIL r0_after_wb got %h want c", WriteData); end
    endtask

    task automatic test_stall();
        mem[65] = 32'hE081_2003;
        idle(); IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2; PCWrite = 1'b1;
        MemReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (PC !== 32'h104) begin errors++; $display("FAIL stall_pc_%0d got %h want 104", k, PC); end
            checks++; if (Instr !== 32'hE281_0005) begin errors++; $display("FAIL stall_ir_%0d got %h want e2810005", k, Instr); end
        end
        MemReady = 1'b1; tick();
        checks++; if (PC !== 32'h108) begin errors++; $display("FAIL unstall_pc got %h want 108", PC); end
        checks++; if (Instr !== 32'hE081_2003) begin errors++; $display("FAIL unstall_ir got %h want e0812003", Instr); end
    endtask

    task automatic test_reset_stall();
        idle(); MemReady = 1'b0; reset = 1'b1; PCWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'd2; ResultSrc = 2'd2;
        tick();
        idle(); #1;
        checks++; if (PC !== RPC) begin errors++; $display("FAIL rst_stall_pc got %h want %h", PC, RPC); end
        checks++; if (Instr !== 32'd0) begin errors++; $display("FAIL rst_stall_ir got %h want 0", Instr); end
    endtask

    task automatic test_alu_flags();
        logic [31:0] xa [4];
        logic [31:0] xb [4];
        logic [2:0]  xo [4];
        logic [31:0] er [4];
        logic [3:0]  ef [4];
        xa = '{32'h8000_0000, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        xb = '{32'd1,         32'd5, 32'd1,         32'd1};
        xo = '{3'd1,          3'd1,  3'd0,          3'd0};
        er = '{32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 32'd0};
        ef = '{4'b0011,       4'b0110, 4'b1001,     4'b0110};
        for (int k = 0; k < 4; k++) begin
            load_ab(xa[k], xb[k]);
            idle(); ALUControl = xo[k]; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
            checks++; if (Adr !== er[k]) begin errors++; $display("FAIL alu_res_%0d got %h want %h", k, Adr, er[k]); end
            checks++; if (ALUFlags !== ef[k]) begin errors++; $display("FAIL alu_flags_%0d got %b want %b", k, ALUFlags, ef[k]); end
        end
    endtask

    task automatic test_mul();
        load_ab(32'h0001_0000, 32'h0001_0000);
        idle(); ALUControl = 3'd4; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
        checks++; if (Adr !== 32'd0) begin errors++; $display("FAIL mul_big got %h want 0", Adr); end
        checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL mul_big_flags got %b want 0100", ALUFlags); end
        load_ab(32'd3, 32'd4);
        idle(); ALUControl = 3'd4; ResultSrc = 2'd2; AdrSrc = 1'b1; #1;
`ifdef MC_DATAPATH_MUL_EN
        checks++; if (Adr !== 32'd12) begin errors++; $display("FAIL mul_3x4 got %h want c", Adr); end
        checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL mul_3x4_flags got %b want 0000", ALUFlags); end
`else
        checks++; if (Adr !== 32'd0) begin errors++; $display("FAIL mul_3x4 got %h want 0", Adr); end
        checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL mul_3x4_flags got %b want 0100", ALUFlags); end
`endif
        ALUControl = 3'd7; #1;
        checks++; if (ALUFlags !== 4'b0100) begin errors++; $display("FAIL op7_flags got %b want 0100", ALUFlags); end
    endtask

    task automatic test_no_bypass();
        write_reg(4'd4, 32'hAAAA_0001);
        mem[0] = 32'h5555_0002;
        idle(); AdrSrc = 1'b1; ResultSrc = 2'd3; tick();
        idle(); RegSrc = 2'b10; ResultSrc = 2'd1; RegWrite = 1'b1; tick();
        checks++; if (WriteData !== 32'hAAAA_0001) begin errors++; $display("FAIL nobypass_old got %h want aaaa0001", WriteData); end
        idle(); RegSrc = 2'b10; tick();
        checks++; if (WriteData !== 32'h5555_0002) begin errors++; $display("FAIL nobypass_new got %h want 55550002", WriteData); end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] alu_r, res, eadr;
        logic [3:0]  fl;
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            PCWrite    = 1'($urandom_range(0, 1));
            AdrSrc     = 1'($urandom_range(0, 1));
            IRWrite    = 1'($urandom_range(0, 1));
            RegSrc     = 2'($urandom_range(0, 3));
            RegWrite   = 1'($urandom_range(0, 1));
            ImmSrc     = 2'($urandom_range(0, 3));
            ALUSrcA    = 1'($urandom_range(0, 1));
            ALUSrcB    = 2'($urandom_range(0, 3));
            ALUControl = 3'($urandom_range(0, 7));
            ResultSrc  = 2'($urandom_range(0, 3));
            MemReady   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) mem[8'($urandom_range(0, 255))] = $urandom;
            #1;
            mcomb(alu_r, fl, res);
            eadr = AdrSrc ? res : m_pc;
            checks++; if (Adr !== eadr) begin errors++; $display("FAIL rnd_adr_%0d got %h want %h", n, Adr, eadr); end
            checks++; if (ALUFlags !== fl) begin errors++; $display("FAIL rnd_flags_%0d got %b want %b", n, ALUFlags, fl); end
            tick();
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc_%0d got %h want %h", n, PC, m_pc); end
            checks++; if (Instr !== m_ir) begin errors++; $display("FAIL rnd_ir_%0d got %h want %h", n, Instr, m_ir); end
            checks++; if (WriteData !== m_b) begin errors++; $display("FAIL rnd_wd_%0d got %h want %h", n, WriteData, m_b); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        idle();
        test_reset();
        test_regwrite();
        test_fetch();
        test_decode_add();
        test_stall();
        test_reset_stall();
        test_alu_flags();
        test_mul();
        test_no_bypass();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle successor to the single-cycle ARM-like CPU datapath. It shares one memory port between instruction fetch and data access, and holds intermediate values in non-architectural registers (IR, Data, A, WriteData, ALUOut). All sequencing control comes from an external multicycle controller FSM. A `MemReady` handshake freezes all state while memory is busy, and the ALU is widened to a 3-bit operation set.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into PC on reset.
- `ADDR_W`, default 32: width of the `Adr` output, legal 16..32. `Adr` carries the low `ADDR_W` bits of the selected 32-bit address.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `PCWrite` in 1: PC load enable.
- `AdrSrc` in 1: address select; 0 = PC, 1 = Result.
- `IRWrite` in 1: instruction register load enable.
- `RegSrc` in 2: read-address select. `RA1` = `RegSrc[0]` ? 15 : `Instr[19:16]`. `RA2` = `RegSrc[1]` ? `Instr[15:12]` : `Instr[3:0]`.
- `RegWrite` in 1: register file write enable; write address is `Instr[15:12]`.
- `ImmSrc` in 2: immediate extension. 00 = zero-extend `Instr[7:0]`. 01 = zero-extend `Instr[11:0]`. 10 = sign-extend `Instr[23:0]`, then shift left by 2. 11 = 0.
- `ALUSrcA` in 1: SrcA select; 0 = A, 1 = PC.
- `ALUSrcB` in 2: SrcB select. 00 = WriteData, 01 = ExtImm, 10 = 32'd4, 11 = 0.
- `ALUControl` in 3: ALU operation.
- `ResultSrc` in 2: Result select. 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = 0.
- `MemReady` in 1: memory handshake; 0 stalls every register update.
- `ReadData` in 32: memory read data.
- `Adr` out `ADDR_W`: memory address (combinational).
- `WriteData` out 32: store data, taken from register B.
- `Instr` out 32: IR contents, for the controller.
- `ALUFlags` out 4: {N,Z,C,V} of the current combinational ALU result.
- `PC` out 32: program counter.

## Operation
- Non-architectural registers are IR, Data, A, B, and ALUOut.
  - IR loads `ReadData` when `IRWrite`.
  - Data, A, B, and ALUOut load unconditionally every unstalled cycle: Data ← `ReadData`, A ← RD1, B ← RD2, ALUOut ← ALUResult.
- PC ← Result when `PCWrite`.
- Register file has 15 physical registers, R0..R14.
  - Write occurs on the clock edge when `RegWrite`.
  - A write to address 15 is ignored.
  - Reading address 15 returns Result. In the decode step this equals PC+4 of the already-incremented PC, i.e. fetch address + 8.
- ALU operations:
  - 000 ADD; 001 SUB (SrcA − SrcB); 010 AND; 011 ORR; 101 EOR; 110 MOV (result = SrcB).
  - 100 is MUL (see Configuration). 111 gives result 0.
- Flags:
  - N = result[31]; Z = (result == 0).
  - C and V are computed for ADD/SUB only and are 0 for all other ops.
  - SUB carry = no-borrow, i.e. SrcA ≥ SrcB unsigned.
  - V = signed overflow of the 32-bit add or subtract.
- Stall: while `MemReady` = 0, PC, IR, Data, A, B, ALUOut and the register file hold their values. Combinational outputs keep tracking the inputs.

## Timing
- Reset:
  - Takes effect at the rising edge with `reset` = 1, regardless of `MemReady`.
  - Reset values: PC = `RESET_PC`; IR, Data, A, B, ALUOut = 0; R0..R14 = 0.
  - After reset, `Adr` = `RESET_PC` when `AdrSrc` = 0.
  - Reset asserted mid-stall wins over the stall.
- Latency:
  - `Adr`, `ALUFlags`, and Result are combinational from the current state and control inputs.
  - Every register write becomes visible one cycle after the enabling edge.
- Simultaneous events:
  - A register file read and write to the same address in one cycle returns the old value; there is no bypass.
  - `PCWrite` and `IRWrite` in the same cycle both take effect, as in the fetch step: IR ← mem[PC], PC ← PC+4.
- `MemReady` is sampled at the same edge as the enables. The enables take effect at the first edge where `MemReady` = 1.

## Configuration
- `MC_DATAPATH_MUL_EN` defined:
  - `ALUControl` 100 = MUL, result = low 32 bits of SrcA × SrcB (unsigned, single cycle).
  - N and Z are updated from the result; C = V = 0.
- Not defined: 100 behaves as 111, giving result 0 and flags 4'b0100.

## Test plan
- Reset with `RESET_PC` = 32'h100 → PC = 32'h100, Instr = 0, `Adr` = 32'h100, ALUOut = 0.
- Fetch with mem[0x100] = 32'hE281_0005: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=1, `ALUSrcB`=10, ALU ADD, `ResultSrc`=10, `PCWrite`=1 → Instr = 32'hE281_0005, PC = 32'h104.
- Decode, then `ADD R0,R1,#5` with R1 = 7 → R0 = 12 after the writeback edge. Reading R15 during decode yields 32'h108.
- Hold `MemReady` = 0 for 3 cycles during fetch with `IRWrite`/`PCWrite` high → PC and IR unchanged for all 3 edges. They update on the first edge with `MemReady` = 1.
- SUB with 32'h8000_0000 − 1 → result 32'h7FFF_FFFF, flags {N,Z,C,V} = 4'b0011. SUB with 5 − 5 → 0, flags 4'b0110.
- MUL with 32'h0001_0000 × 32'h0001_0000: with the macro → 0, flags 4'b0100. MUL with 3 × 4: with the macro → 12; without the macro → 0, flags 4'b0100.
